// File: rtl/pe_float_pkg.sv
// Shared float32 field definitions and helpers for PE shared-resource blocks.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pe_float_pkg;

  localparam int FP32_BIAS   = 127;
  localparam int FP32_EXP_W  = 8;
  localparam int FP32_MANT_W = 23;

  typedef struct packed {
    logic                   sign;
    logic [FP32_EXP_W-1:0]  exp;
    logic [FP32_MANT_W-1:0] mant;
  } fp32_t;

  // Ceiling log2, never below 1 so index buses stay at least one bit wide.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/pe_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request after ptr_i, wrapping.
// Latency: purely combinational.
// Backpressure: en_i low suppresses any grant; the caller owns the pointer.
module pe_rr_arbiter
  import pe_float_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  int               j;
  logic [IDX_W-1:0] jj;

  // Scan from the slot after the last winner so every requester gets a turn.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    jj    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = int'(ptr_i) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      jj = IDX_W'(j);
      if (en_i && !any_o && req_i[jj]) begin
        gnt_o[jj] = 1'b1;
        idx_o     = jj;
        any_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pe_cvt_arbiter.sv
// Shared int32->float32 converter for NUM_REQ PEs; optional per-requester stats under PE_CVT_STATS_EN.
// Latency: handshake edge N -> out_valid after edge N+1 (two registered stages), 1 result/cycle.
// Backpressure: out_ready low holds out_data/out_tag; stage 1 fills, then req_ready drops to zero.
module pe_cvt_arbiter
  import pe_float_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [32*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_data,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  busy
`ifdef PE_CVT_STATS_EN
  ,
  input  logic                  stat_clr,
  output logic [NUM_REQ*16-1:0] stat_count
`endif
);

  localparam int IDX_W = clog2(NUM_REQ);

  logic en1, en2;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               hs;

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  logic             s1_valid_q, s1_valid_d;
  logic             s1_sign_q, s1_sign_d;
  logic [31:0]      s1_mag_q, s1_mag_d;
  logic [4:0]       s1_msb_q, s1_msb_d;
  logic             s1_zero_q, s1_zero_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

  logic             s2_valid_q, s2_valid_d;
  fp32_t            out_data_q, out_data_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;

  logic [31:0] operand;
  logic [31:0] norm;

  assign en2 = ~s2_valid_q | out_ready;
  assign en1 = ~s1_valid_q | en2;

  // Grants are masked during reset so nothing is accepted into a pipeline being cleared.
  pe_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .en_i  (en1 & ~rst),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (hs)
  );

  assign req_ready = gnt;
  assign out_valid = s2_valid_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;
  assign busy      = s1_valid_q | s2_valid_q;

  // Stage 1: pick the granted operand, take its magnitude and find the leading one.
  always_comb begin
    operand = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) operand = req_data[32*i +: 32];
    end
    s1_sign_d = operand[31];
    s1_mag_d  = operand[31] ? (~operand + 32'd1) : operand;
    s1_msb_d  = '0;
    for (int b = 0; b < 32; b++) begin
      if (s1_mag_d[b]) s1_msb_d = 5'(b);
    end
    s1_zero_d  = (s1_mag_d == 32'd0);
    s1_tag_d   = TAG_W'(gnt_idx);
    s1_valid_d = en1 ? hs : s1_valid_q;
    rr_ptr_d   = hs ? gnt_idx : rr_ptr_q;
  end

  // Stage 2: shift the leading one to bit 31, drop it, keep the next 23 bits (truncation).
  always_comb begin
    norm       = s1_mag_q << (5'd31 - s1_msb_q);
    s2_valid_d = en2 ? s1_valid_q : s2_valid_q;
    out_data_d = out_data_q;
    out_tag_d  = out_tag_q;
    if (en2 && s1_valid_q) begin
      out_tag_d = s1_tag_q;
      if (s1_zero_q) begin
        out_data_d = '0;
      end else begin
        out_data_d.sign = s1_sign_q;
        out_data_d.exp  = FP32_EXP_W'(FP32_BIAS) + FP32_EXP_W'(s1_msb_q);
        out_data_d.mant = norm[30:8];
      end
    end
  end

  // Stage 1 registers advance on en1; the pointer moves only on a handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q   <= IDX_W'(NUM_REQ - 1);
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_mag_q   <= '0;
      s1_msb_q   <= '0;
      s1_zero_q  <= 1'b0;
      s1_tag_q   <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      s1_valid_q <= s1_valid_d;
      if (en1) begin
        s1_sign_q <= s1_sign_d;
        s1_mag_q  <= s1_mag_d;
        s1_msb_q  <= s1_msb_d;
        s1_zero_q <= s1_zero_d;
        s1_tag_q  <= s1_tag_d;
      end
    end
  end

  // Output stage registers; data only changes when a new result moves in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      out_data_q <= '0;
      out_tag_q  <= '0;
    end else begin
      s2_valid_q <= s2_valid_d;
      out_data_q <= out_data_d;
      out_tag_q  <= out_tag_d;
    end
  end

`ifdef PE_CVT_STATS_EN
  logic [15:0] cnt_q [NUM_REQ];
  logic [15:0] cnt_d [NUM_REQ];

  // Per-requester handshake counters; a clear beats a coincident increment.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (stat_clr)    cnt_d[i] = '0;
      else if (gnt[i]) cnt_d[i] = cnt_q[i] + 16'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    assign stat_count[16*g +: 16] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_pe_cvt_arbiter.sv
// Self-checking bench for pe_cvt_arbiter: directed cases plus randomized traffic.
// Reference: arithmetic int->float model, FIFO scoreboard, capacity/round-robin rules.
// Inputs driven 1 time unit after posedge, outputs sampled on negedge.
module tb_pe_cvt_arbiter;

  localparam int NUM_REQ = 4;
  localparam int TAG_W   = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [32*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           out_data;
  logic [TAG_W-1:0]      out_tag;
  logic                  busy;
  logic                  stat_clr;
  logic [NUM_REQ*16-1:0] stat_count;

  always #5 clk = ~clk;

  pe_cvt_arbiter #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .busy      (busy)
`ifdef PE_CVT_STATS_EN
    ,
    .stat_clr  (stat_clr),
    .stat_count(stat_count)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference conversion from plain integer arithmetic.
  function automatic logic [31:0] ref_cvt(input logic [31:0] a);
    longint v, m, p, frac;
    int e;
    v = longint'($signed(a));
    if (v == 0) return 32'h0;
    m = (v < 0) ? -v : v;
    p = 1;
    e = 0;
    while (p * 2 <= m) begin
      p = p * 2;
      e++;
    end
    frac = ((m - p) * 64'sd8388608) / p;
    return {(v < 0), 8'(127 + e), frac[22:0]};
  endfunction

  typedef struct {
    logic [31:0] d;
    int          t;
    int          c;
  } item_t;

  item_t q[$];
  int    last_g = NUM_REQ - 1;
  int    cyc = 0;
  bit    mon_en = 0;

  logic [NUM_REQ-1:0] exp_rdy;
  int                 g;
  bit                 can;
  item_t              it;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: capacity of two in flight, round-robin order, in-order delivery, 2-cycle latency.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      exp_rdy = '0;
      g = -1;
      can = (q.size() < 2) || out_ready;
      if (can) begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          int j;
          j = (last_g + k) % NUM_REQ;
          if (g < 0 && req_valid[j]) g = j;
        end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("busy", 32'(busy), 32'(q.size() > 0));
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0 && cyc >= q[0].c + 2));
      if (out_valid && q.size() > 0) begin
        chk("out_data", out_data, q[0].d);
        chk("out_tag", 32'(out_tag), 32'(q[0].t));
        if (out_ready) void'(q.pop_front());
      end
      if (g >= 0) begin
        it.d = ref_cvt(req_data[32*g +: 32]);
        it.t = g;
        it.c = cyc;
        q.push_back(it);
        last_g = g;
      end
    end
  end

  task automatic cvt_one(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bit ok;
    @(posedge clk); #1;
    req_valid = 4'b0100;
    req_data[95:64] = a;
    out_ready = 1'b1;
    ok = 0;
    for (int k = 0; k < 10 && !ok; k++) begin
      @(negedge clk);
      if (req_ready[2]) ok = 1;
    end
    chk({tag, "_grant"}, 32'(ok), 32'd1);
    @(posedge clk); #1;
    req_valid = '0;
    ok = 0;
    for (int k = 0; k < 10 && !ok; k++) begin
      @(negedge clk);
      if (out_valid) ok = 1;
    end
    chk({tag, "_done"}, 32'(ok), 32'd1);
    chk(tag, out_data, exp);
  endtask

  logic [31:0] specials [8];
  logic [31:0] hold_d;
  logic [TAG_W-1:0] hold_t;
  int prev_tag;

  initial begin
    specials = '{32'h1, 32'hFFFFFFFF, 32'h0, 32'h7FFFFFFF,
                 32'h80000000, 32'h01000001, 32'h00FFFFFF, 32'hFF000000};
    rst = 1'b1;
    req_valid = '1;
    req_data = '0;
    out_ready = 1'b0;
    stat_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1;

    // Single request from requester 0, exact latency.
    @(posedge clk); #1;
    req_valid = 4'b0001;
    req_data[31:0] = 32'd1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("t1_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk("t1_not_yet", 32'(out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_data", out_data, 32'h3F800000);
    chk("t1_tag", 32'(out_tag), 32'd0);

    // Conversion corner values via requester 2.
    cvt_one("cvt_m1", 32'hFFFFFFFF, 32'hBF800000);
    cvt_one("cvt_0", 32'h00000000, 32'h00000000);
    cvt_one("cvt_max", 32'h7FFFFFFF, 32'h4EFFFFFF);
    cvt_one("cvt_min", 32'h80000000, 32'hCF000000);
    cvt_one("cvt_trunc", 32'h01000001, 32'h4B800000);

    // All requesters valid, continuous drain: tags rotate, one result per cycle.
    @(posedge clk); #1;
    req_valid = '1;
    for (int i = 0; i < NUM_REQ; i++) req_data[32*i +: 32] = $urandom;
    out_ready = 1'b1;
    prev_tag = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        chk("rr_full_rate", 32'(out_valid), 32'd1);
        if (k >= 3) chk("rr_seq", 32'(out_tag), 32'((prev_tag + 1) % NUM_REQ));
        prev_tag = int'(out_tag);
      end
    end

    // Backpressure for 5 cycles: outputs hold, no grants.
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) begin
        hold_d = out_data;
        hold_t = out_tag;
      end else begin
        chk("bp_hold_data", out_data, hold_d);
        chk("bp_hold_tag", 32'(out_tag), 32'(hold_t));
      end
      chk("bp_no_grant", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_data", out_data, hold_d);
    chk("bp_release_grant", 32'(req_ready != 0), 32'd1);
    repeat (4) @(posedge clk);
    #1;

    // Reset with results in flight.
    out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    q.delete();
    last_g = NUM_REQ - 1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    req_valid = '1;
    @(negedge clk);
    chk("post_rst_grant", 32'(req_ready), 32'd1);
    chk("post_rst_no_stale", 32'(out_valid), 32'd0);
    repeat (4) @(posedge clk);
    #1;

`ifdef PE_CVT_STATS_EN
    req_valid = '0;
    stat_clr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    stat_clr = 1'b0;
    req_valid = 4'b0010;
    repeat (3) @(posedge clk);
    #1;
    stat_clr = 1'b1;
    @(negedge clk);
    chk("stat_count1", 32'(stat_count[31:16]), 32'd3);
    @(posedge clk); #1;
    stat_clr = 1'b0;
    req_valid = '0;
    @(negedge clk);
    chk("stat_clr_wins", 32'(stat_count[31:16]), 32'd0);
`endif

    // Randomized traffic against the scoreboard.
    for (int n = 0; n < 1500; n++) begin
      @(posedge clk); #1;
      req_valid = NUM_REQ'($urandom);
      for (int i = 0; i < NUM_REQ; i++) begin
        if ($urandom_range(0, 3) == 0) req_data[32*i +: 32] = specials[$urandom_range(0, 7)];
        else req_data[32*i +: 32] = $urandom;
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end

    // Drain.
    @(posedge clk); #1;
    req_valid = '0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("drain_empty", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
